floor_display_driver: RTL
=========================

FLOOR_DISPLAY_DRIVER -- requirements
Module: floor_display_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000, clocks per digit-refresh tick (min 4).
REQ-002 SHALL have parameter BLINK_FRAMES, default 64, frames per door-lamp blink half-period (min 1).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port upd_valid  input  1  new display data offered.
REQ-006 SHALL have port upd_ready  output  1  display accepts data this cycle.
REQ-007 SHALL have port floor  input  4  floor number 0..15, sampled on transfer.
REQ-008 SHALL have port dir  input  2  00 idle, 01 up, 10 down, 11 fault; sampled on transfer.
REQ-009 SHALL have port door_open  input  1  door state, sampled on transfer.
REQ-010 SHALL have port an_n  output  4  active-low digit enables, bit i = digit i.
REQ-011 SHALL have port seg_n  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-012 SHALL have port dp_n  output  1  active-low decimal point (heartbeat).

Function
REQ-013 Tick counter SHALL count 0..CLK_DIV-1 and wrap; tick = cycle where count==CLK_DIV-1.
REQ-014 Digit index SHALL advance 0->1->2->3->0 on each tick; frame = 4 ticks; frame end = tick with index 3.
REQ-015 On each tick cycle an_n SHALL be 4'b1111 for exactly one clock (anti-ghost blanking), then enable the new digit.
REQ-016 Outputs SHALL be registered: one clock latency from index/shadow change to an_n/seg_n.
REQ-017 Digit 0 SHALL show floor units (floor mod 10) as decimal glyph; 0 = seg_n 7'b1000000.
REQ-018 Digit 1 SHALL show '1' (seg_n 7'b1111001) when floor>=10, else blank (7'b1111111).
REQ-019 Digit 2 SHALL show dir: idle = g only; up = a,b,f; down = c,d,e; fault = all seven lit.
REQ-020 Digit 3 SHALL show 'O' (a..f lit) when shadow door_open=1 and blink phase=1, else blank.
REQ-021 Blink phase SHALL toggle every BLINK_FRAMES frame ends; dp_n SHALL be 0 only while digit 0 enabled and blink phase=1.
REQ-022 upd_ready SHALL be 1 only in the frame-end tick cycle, 0 otherwise.
REQ-023 Transfer SHALL occur when upd_valid && upd_ready; floor/dir/door_open then load shadow registers.
REQ-024 Loaded values SHALL first appear on digit 0 of the next frame; no frame ever mixes old and new data.
REQ-025 upd_valid without upd_ready SHALL be ignored; the source holds valid until transfer.
REQ-026 Tick counter, index, blink counter SHALL wrap silently; no overflow state exists.

Reset
REQ-027 While rst_n=0 at a clk edge: an_n=4'b1111, seg_n=7'b1111111, dp_n=1, upd_ready=0.
REQ-028 Reset SHALL clear tick count, digit index, blink counter, blink phase to 0; shadow floor=0, dir=00, door_open=0.
REQ-029 Reset asserted mid-frame or in a transfer cycle SHALL discard the transfer; reset wins.
REQ-030 First clock after rst_n rises SHALL drive an_n=4'b1110, seg_n=7'b1000000.

Structure
REQ-031 Shared package elevator_pkg SHALL hold dir encodings, segment glyph constants, and blank constant.
REQ-032 A combinational sub-module seg7_decoder (4-bit value -> 7 active-low segments) SHALL be instantiated once.

Verification (CLK_DIV=4, BLINK_FRAMES=2)
REQ-033 Reset release -> an_n 1110 with seg_n 1000000 next clock; an_n 1111 at cycle 3; 1101 at cycle 4.
REQ-034 floor=12, dir=01, upd_valid held -> transfer at first frame end; next frame digits show 2, 1, up (a,b,f), blank.
REQ-035 upd_valid pulsed one cycle mid-frame -> no transfer, display unchanged.
REQ-036 door_open=1 transferred -> digit 3 shows 'O' on alternating 2-frame periods; dp_n mirrors the phase on digit 0.
REQ-037 dir=11 -> digit 2 seg_n 7'b0000000; floor=9 -> digit 1 blank.
REQ-038 rst_n low during transfer cycle -> shadow stays 0, outputs at reset values next edge.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator floor display: travel direction and the
// active-low seven-segment glyphs, ordered {g,f,e,d,c,b,a}.
package elevator_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE  = 2'b00,
    DIR_UP    = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_FAULT = 2'b11
  } dir_e;

  localparam logic [6:0] SEG_BLANK     = 7'b1111111;
  localparam logic [6:0] SEG_0         = 7'b1000000;
  localparam logic [6:0] SEG_1         = 7'b1111001;
  localparam logic [6:0] SEG_2         = 7'b0100100;
  localparam logic [6:0] SEG_3         = 7'b0110000;
  localparam logic [6:0] SEG_4         = 7'b0011001;
  localparam logic [6:0] SEG_5         = 7'b0010010;
  localparam logic [6:0] SEG_6         = 7'b0000010;
  localparam logic [6:0] SEG_7         = 7'b1111000;
  localparam logic [6:0] SEG_8         = 7'b0000000;
  localparam logic [6:0] SEG_9         = 7'b0010000;

  // Direction arrows: idle is a bar, up is the top cap, down the bottom cup.
  localparam logic [6:0] SEG_DIR_IDLE  = 7'b0111111;
  localparam logic [6:0] SEG_DIR_UP    = 7'b1011100;
  localparam logic [6:0] SEG_DIR_DOWN  = 7'b1100011;
  localparam logic [6:0] SEG_DIR_FAULT = 7'b0000000;
  localparam logic [6:0] SEG_DOOR_O    = 7'b1000000;

  function automatic logic [3:0] floorUnits(input logic [3:0] f);
    return (f >= 4'd10) ? (f - 4'd10) : f;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational decimal-digit to active-low seven-segment decoder.
// Values above 9 never reach it from the floor path and show blank.
module seg7_decoder
  import elevator_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_segN
);

  always_comb begin
    o_segN = SEG_BLANK;
    case (i_value)
      4'd0: o_segN = SEG_0;
      4'd1: o_segN = SEG_1;
      4'd2: o_segN = SEG_2;
      4'd3: o_segN = SEG_3;
      4'd4: o_segN = SEG_4;
      4'd5: o_segN = SEG_5;
      4'd6: o_segN = SEG_6;
      4'd7: o_segN = SEG_7;
      4'd8: o_segN = SEG_8;
      4'd9: o_segN = SEG_9;
      default: o_segN = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/floor_display_driver.sv
// Multiplexed four-digit elevator display: floor units, tens '1', direction
// arrow and blinking door lamp, with frame-aligned shadow updates.
module floor_display_driver #(
  parameter int CLK_DIV      = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [3:0] floor,
  input  logic [1:0] dir,
  input  logic       door_open,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  import elevator_pkg::*;

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] r_tickCnt;
  logic [1:0]       r_digitIdx;
  logic [BLK_W-1:0] r_blinkCnt;
  logic             r_blinkPhase;
  logic [3:0]       r_floor;
  dir_e             r_dir;
  logic             r_door;
  logic [3:0]       r_anN;
  logic [6:0]       r_segN;
  logic             r_dpN;

  logic             w_tick;
  logic             w_frameEnd;
  logic             w_xfer;
  logic [3:0]       w_unitsVal;
  logic [6:0]       w_unitsSeg;
  logic [6:0]       w_digitSeg;

  assign w_tick     = (r_tickCnt == CNT_W'(CLK_DIV - 1));
  assign w_frameEnd = w_tick && (r_digitIdx == 2'd3);
  assign upd_ready  = w_frameEnd && rst_n;
  assign w_xfer     = upd_valid && upd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tickCnt  <= '0;
      r_digitIdx <= '0;
    end else begin
      r_tickCnt  <= w_tick ? '0 : r_tickCnt + 1'b1;
      if (w_tick)
        r_digitIdx <= r_digitIdx + 2'd1;
    end
  end

  // Shadow data and blink phase change only on a frame end, so a frame never mixes them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
      r_floor      <= '0;
      r_dir        <= DIR_IDLE;
      r_door       <= 1'b0;
    end else begin
      if (w_frameEnd) begin
        if (r_blinkCnt == BLK_W'(BLINK_FRAMES - 1)) begin
          r_blinkCnt   <= '0;
          r_blinkPhase <= ~r_blinkPhase;
        end else begin
          r_blinkCnt <= r_blinkCnt + 1'b1;
        end
      end
      if (w_xfer) begin
        r_floor <= floor;
        r_dir   <= dir_e'(dir);
        r_door  <= door_open;
      end
    end
  end

  assign w_unitsVal = floorUnits(r_floor);

  seg7_decoder u_seg7Decoder (
    .i_value (w_unitsVal),
    .o_segN  (w_unitsSeg)
  );

  always_comb begin
    w_digitSeg = SEG_BLANK;
    case (r_digitIdx)
      2'd0: w_digitSeg = w_unitsSeg;
      2'd1: w_digitSeg = (r_floor >= 4'd10) ? SEG_1 : SEG_BLANK;
      2'd2: begin
        case (r_dir)
          DIR_IDLE:  w_digitSeg = SEG_DIR_IDLE;
          DIR_UP:    w_digitSeg = SEG_DIR_UP;
          DIR_DOWN:  w_digitSeg = SEG_DIR_DOWN;
          DIR_FAULT: w_digitSeg = SEG_DIR_FAULT;
          default:   w_digitSeg = SEG_BLANK;
        endcase
      end
      2'd3: w_digitSeg = (r_door && r_blinkPhase) ? SEG_DOOR_O : SEG_BLANK;
      default: w_digitSeg = SEG_BLANK;
    endcase
  end

  // The tick cycle blanks all anodes for one clock before the next digit lights.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_anN  <= 4'b1111;
      r_segN <= SEG_BLANK;
      r_dpN  <= 1'b1;
    end else if (w_tick) begin
      r_anN  <= 4'b1111;
      r_segN <= SEG_BLANK;
      r_dpN  <= 1'b1;
    end else begin
      r_anN  <= ~(4'b0001 << r_digitIdx);
      r_segN <= w_digitSeg;
      r_dpN  <= ~((r_digitIdx == 2'd0) && r_blinkPhase);
    end
  end

  assign an_n  = r_anN;
  assign seg_n = r_segN;
  assign dp_n  = r_dpN;

endmodule
